// File: rtl/tick_scheduler_if.sv
// Control/status bundle between game-level logic and the tick scheduler.
// master drives start/pause/level/hit; slave (the scheduler) returns ticks and status.
interface tick_scheduler_if;
    logic       start;
    logic       pause_req;
    logic [1:0] level;
    logic       hit;
    logic       move_tick;
    logic       life_tick;
    logic [1:0] lives;
    logic [1:0] state;
    logic       game_over;

    modport master (
        output start, pause_req, level, hit,
        input  move_tick, life_tick, lives, state, game_over
    );

    modport slave (
        input  start, pause_req, level, hit,
        output move_tick, life_tick, lives, state, game_over
    );
endinterface

// File: rtl/tick_scheduler.sv
// Game timebase: single-cycle move/life enable ticks, IDLE/RUN/PAUSE/OVER sequencing and lives.
//  state | meaning
//  IDLE  | after reset, counters held at 0, waiting for start
//  RUN   | counters advance, ticks generated, hits consume lives
//  PAUSE | counters frozen, no ticks, hits ignored
//  OVER  | lives exhausted, game_over high, start reloads and runs
module tick_scheduler #(
    parameter logic [27:0] MOVE_DIV_BASE = 28'd1_666_668,
    parameter logic [27:0] LIFE_DIV      = 28'd10_500_000,
    parameter logic [1:0]  MAX_LIVES     = 2'd3
) (
    input  logic              clk,
    input  logic              RST,
    tick_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [27:0] move_cnt_q, move_cnt_d;
    logic [27:0] life_cnt_q, life_cnt_d;
    logic [27:0] period_q, period_d;
    logic [1:0]  lives_q, lives_d;
    logic        move_tick_q, move_tick_d;
    logic        life_tick_q, life_tick_d;
    logic        over_q, over_d;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            move_cnt_q  <= '0;
            life_cnt_q  <= '0;
            period_q    <= MOVE_DIV_BASE;
            lives_q     <= '0;
            move_tick_q <= 1'b0;
            life_tick_q <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            move_cnt_q  <= move_cnt_d;
            life_cnt_q  <= life_cnt_d;
            period_q    <= period_d;
            lives_q     <= lives_d;
            move_tick_q <= move_tick_d;
            life_tick_q <= life_tick_d;
            over_q      <= over_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        move_cnt_d  = move_cnt_q;
        life_cnt_d  = life_cnt_q;
        period_d    = period_q;
        lives_d     = lives_q;
        move_tick_d = 1'b0;
        life_tick_d = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_d    = S_RUN;
                    lives_d    = MAX_LIVES;
                    move_cnt_d = '0;
                    life_cnt_d = '0;
                    period_d   = MOVE_DIV_BASE >> bus.level;
                end
            end
            S_RUN: begin
                // Losing the last life wins over pause and suppresses ticks
                if (bus.hit && lives_q == 2'd1) begin
                    lives_d = 2'd0;
                    state_d = S_OVER;
                end else if (bus.pause_req) begin
                    state_d = S_PAUSE;
                    if (bus.hit && lives_q != 2'd0)
                        lives_d = lives_q - 2'd1;
                end else begin
                    if (bus.hit && lives_q != 2'd0)
                        lives_d = lives_q - 2'd1;
                    // New level only applies at the wrap so a period is never cut short
                    if (move_cnt_q == period_q - 28'd1) begin
                        move_cnt_d  = '0;
                        move_tick_d = 1'b1;
                        period_d    = MOVE_DIV_BASE >> bus.level;
                    end else begin
                        move_cnt_d = move_cnt_q + 28'd1;
                    end
                    if (life_cnt_q == LIFE_DIV - 28'd1) begin
                        life_cnt_d  = '0;
                        life_tick_d = 1'b1;
                    end else begin
                        life_cnt_d = life_cnt_q + 28'd1;
                    end
                end
            end
            S_PAUSE: begin
                if (!bus.pause_req)
                    state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase

        over_d = (state_d == S_OVER);
    end

    assign bus.move_tick = move_tick_q;
    assign bus.life_tick = life_tick_q;
    assign bus.lives     = lives_q;
    assign bus.state     = state_q;
    assign bus.game_over = over_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed scenarios plus random stimulus for tick_scheduler, checked every cycle
// against an event-level model of the game rules.
module tb_tick_scheduler;

    localparam int BASE  = 16;
    localparam int LDIV  = 40;
    localparam int MAXL  = 3;

    logic clk;
    logic RST;
    tick_scheduler_if bus();

    tick_scheduler #(
        .MOVE_DIV_BASE(28'd16),
        .LIFE_DIV     (28'd40),
        .MAX_LIVES    (2'd3)
    ) dut (
        .clk(clk),
        .RST(RST),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0 idle, 1 run, 2 pause, 3 over; elapsed = counting cycles since last tick
    int m_mode, m_lives, m_move_el, m_life_el, m_period;
    int m_move_tick, m_life_tick;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_lives = 0; m_move_el = 0; m_life_el = 0;
        m_period = BASE; m_move_tick = 0; m_life_tick = 0;
    endtask

    task automatic model_edge();
        m_move_tick = 0;
        m_life_tick = 0;
        if (!RST) begin
            model_reset();
            return;
        end
        case (m_mode)
            0, 3: if (bus.start) begin
                m_mode = 1; m_lives = MAXL; m_move_el = 0; m_life_el = 0;
                m_period = BASE / (1 << bus.level);
            end
            1: begin
                if (bus.hit && m_lives == 1) begin
                    m_lives = 0; m_mode = 3;
                end else if (bus.pause_req) begin
                    if (bus.hit) m_lives = m_lives - 1;
                    m_mode = 2;
                end else begin
                    if (bus.hit) m_lives = m_lives - 1;
                    m_move_el++;
                    if (m_move_el == m_period) begin
                        m_move_tick = 1; m_move_el = 0;
                        m_period = BASE / (1 << bus.level);
                    end
                    m_life_el++;
                    if (m_life_el == LDIV) begin
                        m_life_tick = 1; m_life_el = 0;
                    end
                end
            end
            default: if (!bus.pause_req) m_mode = 1;
        endcase
    endtask

    task automatic compare_all();
        chk("move_tick", int'(bus.move_tick), m_move_tick);
        chk("life_tick", int'(bus.life_tick), m_life_tick);
        chk("lives",     int'(bus.lives),     m_lives);
        chk("state",     int'(bus.state),     m_mode);
        chk("game_over", int'(bus.game_over), (m_mode == 3) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    task automatic pulse_hit();
        bus.hit = 1'b1; step(); bus.hit = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.pause_req = 1'b0; bus.level = 2'd0; bus.hit = 1'b0;
        RST = 1'b0;
        model_reset();
        #12;
        compare_all();
        RST = 1'b1;

        // Start at level 0: 16-cycle move period, 40-cycle life period
        run(3);
        pulse_start();
        run(85);

        // Level change mid-period applies only after the current wrap
        bus.level = 2'd2;
        run(40);
        bus.level = 2'd0;
        run(20);

        // Pause while the move counter sits at 7
        begin
            int guard = 0;
            while (m_move_el != 7 && guard < 40) begin step(); guard++; end
            chk("pause_align", m_move_el, 7);
        end
        bus.pause_req = 1'b1;
        run(10);
        bus.pause_req = 1'b0;
        run(20);

        // Three hits to game over, then restart from OVER
        pulse_hit(); run(5);
        pulse_hit(); run(5);
        pulse_hit(); run(20);
        pulse_hit(); run(3);
        pulse_start();
        run(10);

        // Hit and pause in the same cycle at lives=2; start ignored while paused
        pulse_hit(); run(4);
        bus.hit = 1'b1; bus.pause_req = 1'b1;
        step();
        bus.hit = 1'b0;
        run(3);
        pulse_start();
        pulse_hit();
        run(3);
        bus.pause_req = 1'b0;
        run(30);

        // Asynchronous reset mid-RUN, checked before any clock edge
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        compare_all();
        run(2);
        RST = 1'b1;
        run(3);

        // Random play
        for (int i = 0; i < 4000; i++) begin
            bus.start = ($urandom_range(0, 39) == 0);
            bus.hit   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) bus.pause_req = ~bus.pause_req;
            if ($urandom_range(0, 24) == 0) bus.level = 2'($urandom_range(0, 3));
            step();
        end
        bus.start = 1'b0; bus.hit = 1'b0; bus.pause_req = 1'b0;
        run(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
